// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative restoring divider: FSM encodings,
// iteration count and datapath width.
package div_iter_pkg;

  localparam int          DATALENGTH = 32;
  localparam logic [31:0] ZEROWORD   = 32'h0000_0000;
  localparam int          DIV_ITER   = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one and
// subtract the divisor from the partial remainder when it fits.
module div_iter_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0]   rem_sh;
  logic [W+1:0] trial;

  always_comb begin
    rem_sh = {rem[W-1:0], quo[W-1]};
    // One extra bit so the borrow shows up as a sign bit.
    trial  = {1'b0, rem_sh} - {2'b00, dvs};
    if (!trial[W+1]) begin
      rem_nxt = trial[W:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh;
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional macro DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_ITER
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 annul,
  output logic                 div_start,
  output logic                 div_end,
  output logic [DIV_WIDTH-1:0] div_hi_data,
  output logic [DIV_WIDTH-1:0] div_lo_data
);

  localparam int W     = DIV_WIDTH;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic [W-1:0] dvd_abs;
  logic [W-1:0] dvs_abs;
  logic [W:0]   step_rem;
  logic [W-1:0] step_quo;

  div_iter_step #(.W(W)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    dvd_abs = (signed_div && dividend[W-1]) ? -dividend : dividend;
    dvs_abs = (signed_div && divisor[W-1])  ? -divisor  : divisor;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          dvs_d   = dvs_abs;
          q_neg_d = signed_div & (dividend[W-1] ^ divisor[W-1]);
          r_neg_d = signed_div & dividend[W-1];
          rem_d   = '0;
          quo_d   = dvd_abs;
          cnt_d   = '0;
          state_d = DIV_CALC;
          // Divide by zero: preload the fixed result and bypass sign correction.
          if (divisor == '0) begin
            rem_d   = {1'b0, dividend};
            quo_d   = '1;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = DIV_FIX;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (dvd_abs < dvs_abs) begin
            rem_d   = {1'b0, dvd_abs};
            quo_d   = '0;
            state_d = DIV_FIX;
          end
`endif
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        lo_d    = q_neg_q ? -quo_q : quo_q;
        hi_d    = r_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        state_d = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // A flush wins over everything and leaves the last result visible.
    if (annul) begin
      state_d = DIV_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign div_start   = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign div_end     = (state_q == DIV_DONE);
  assign div_hi_data = hi_q;
  assign div_lo_data = lo_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vectors, random operations against
// an arithmetic reference model, annul, mid-operation reset and back-to-back.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        annul = 1'b0;
  logic        div_start;
  logic        div_end;
  logic [31:0] div_hi_data;
  logic [31:0] div_lo_data;

  int errors = 0;
  int checks = 0;

  div_iter dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_div  (signed_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .annul       (annul),
    .div_start   (div_start),
    .div_end     (div_end),
    .div_hi_data (div_hi_data),
    .div_lo_data (div_lo_data)
  );

  always #5 clock = ~clock;

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sa, sb, lq, lr, aa, ab;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      lat = 2;
      return;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0];
    r = lr[31:0];
    aa = (sa < 0) ? -sa : sa;
    ab = (sb < 0) ? -sb : sb;
    lat = 34;
`ifdef DIV_EARLY_OUT_EN
    if (aa < ab) lat = 2;
`else
    if (aa < 0 || ab < 0) lat = 34;
`endif
  endfunction

  // Drives one operation (start held until div_end) and records what was observed.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output bit busy_ok, output bit single_pulse);
    lat = -1;
    q = 'x;
    r = 'x;
    busy_ok = 1'b1;
    @(negedge clock);
    start = 1'b1;
    signed_div = s;
    dividend = a;
    divisor = b;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (div_end) begin
        lat = k;
        q = div_lo_data;
        r = div_hi_data;
        if (div_start) busy_ok = 1'b0;
        break;
      end else if (!div_start) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clock);
    single_pulse = !div_end && !div_start;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (div_start !== 1'b0 || div_end !== 1'b0 || div_hi_data !== 32'd0 || div_lo_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: start=%b end=%b hi=%h lo=%h, required 0 0 0 0",
               div_start, div_end, div_hi_data, div_lo_data);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (div_start !== 1'b0 || div_end !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: start=%b end=%b, required 0 0", div_start, div_end);
    end
  endtask

  task automatic test_directed();
    bit          vs[8] = '{0, 1, 1, 1, 0, 0, 1, 0};
    logic [31:0] va[8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'd3,
                           32'hFFFF_FFFB, 32'hFFFF_FFFF};
    logic [31:0] vb[8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd10,
                           32'd0, 32'd1};
    logic [31:0] eq[8] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                           32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] er[8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5, 32'd3,
                           32'hFFFF_FFFB, 32'd0};
    int          el[8];
    int lat;
    logic [31:0] q, r;
    bit busy_ok, single;
`ifdef DIV_EARLY_OUT_EN
    el = '{34, 34, 34, 34, 2, 2, 2, 34};
`else
    el = '{34, 34, 34, 34, 2, 34, 2, 34};
`endif
    for (int i = 0; i < 8; i++) begin
      run_op(vs[i], va[i], vb[i], lat, q, r, busy_ok, single);
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        errors++;
        $display("FAIL directed_%0d_result: lo=%h hi=%h, required lo=%h hi=%h", i, q, r, eq[i], er[i]);
      end
      checks++;
      if (lat !== el[i]) begin
        errors++;
        $display("FAIL directed_%0d_latency: div_end at %0d, required %0d", i, lat, el[i]);
      end
      checks++;
      if (!busy_ok || !single) begin
        errors++;
        $display("FAIL directed_%0d_handshake: busy_ok=%b single_pulse=%b, required 1 1", i, busy_ok, single);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, mq, mr;
    bit s, busy_ok, single;
    int lat, mlat;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -32'($urandom_range(1, 15));
        4:       begin b = $urandom; a = $urandom_range(0, 200); end
        default: b = $urandom;
      endcase
      model(s, a, b, mq, mr, mlat);
      run_op(s, a, b, lat, q, r, busy_ok, single);
      checks++;
      if (q !== mq || r !== mr) begin
        errors++;
        $display("FAIL random_%0d_result: s=%b %h/%h lo=%h hi=%h, required lo=%h hi=%h",
                 i, s, a, b, q, r, mq, mr);
      end
      checks++;
      if (lat !== mlat || !busy_ok || !single) begin
        errors++;
        $display("FAIL random_%0d_timing: lat=%0d busy_ok=%b single=%b, required lat=%0d 1 1",
                 i, lat, busy_ok, single, mlat);
      end
    end
  endtask

  task automatic test_annul();
    logic [31:0] q, r;
    bit busy_ok, single, seen_end;
    int lat;
    run_op(1'b0, 32'd9, 32'd3, lat, q, r, busy_ok, single);
    @(negedge clock);
    start = 1'b1;
    signed_div = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd3;
    repeat (10) @(negedge clock);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clock);
    annul = 1'b0;
    checks++;
    if (div_start !== 1'b0 || div_end !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle: start=%b end=%b, required 0 0", div_start, div_end);
    end
    seen_end = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (div_end || div_start) seen_end = 1'b1;
    end
    checks++;
    if (seen_end) begin
      errors++;
      $display("FAIL annul_no_end: activity seen after annul, required none");
    end
    checks++;
    if (div_lo_data !== 32'd3 || div_hi_data !== 32'd0) begin
      errors++;
      $display("FAIL annul_hold: lo=%h hi=%h, required lo=3 hi=0", div_lo_data, div_hi_data);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clock);
    start = 1'b1;
    signed_div = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd7;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (div_start !== 1'b0 || div_end !== 1'b0 || div_hi_data !== 32'd0 || div_lo_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: start=%b end=%b hi=%h lo=%h, required 0 0 0 0",
               div_start, div_end, div_hi_data, div_lo_data);
    end
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (div_end || div_start) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_resume: activity seen after reset, required none");
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [31:0] q1, r1, q2, r2;
    bit idle_gap;
    lat1 = -1;
    lat2 = -1;
    q1 = 'x; r1 = 'x; q2 = 'x; r2 = 'x;
    idle_gap = 1'b0;
    @(negedge clock);
    start = 1'b1;
    signed_div = 1'b0;
    dividend = 32'd9;
    divisor = 32'd3;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (div_end) begin lat1 = k; q1 = div_lo_data; r1 = div_hi_data; break; end
    end
    dividend = 32'd20;
    divisor = 32'd6;
    @(negedge clock);
    idle_gap = !div_start && !div_end;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (div_end) begin lat2 = k; q2 = div_lo_data; r2 = div_hi_data; break; end
    end
    start = 1'b0;
    checks++;
    if (q1 !== 32'd3 || r1 !== 32'd0 || lat1 !== 34) begin
      errors++;
      $display("FAIL b2b_first: lo=%h hi=%h lat=%0d, required lo=3 hi=0 lat=34", q1, r1, lat1);
    end
    checks++;
    if (!idle_gap) begin
      errors++;
      $display("FAIL b2b_gap: no idle cycle after done, required one");
    end
    checks++;
    if (q2 !== 32'd3 || r2 !== 32'd2 || lat2 !== 34) begin
      errors++;
      $display("FAIL b2b_second: lo=%h hi=%h lat=%0d, required lo=3 hi=2 lat=34", q2, r2, lat2);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider for the EX stage, executing DIV and DIVU. It accepts operands from the EX-stage operand muxes and produces the `div_start`/`div_end` handshake and the `div_hi_data`/`div_lo_data` result that the EX-stage HI/LO write-data selector consumes. That selector decodes the handshake into the stall status used by the hazard unit.

## Interface
Parameters:
- `DIV_WIDTH`, default 32: operand and result width; iteration count equals `DIV_WIDTH`.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX stage holds a DIV/DIVU; level, held until `div_end` is seen.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `dividend`  in  DIV_WIDTH  rs value; sampled on acceptance.
- `divisor`  in  DIV_WIDTH  rt value; sampled on acceptance.
- `annul`  in  1  pipeline flush (exception/eret); aborts any operation.
- `div_start`  out  1  division in progress (busy).
- `div_end`  out  1  one-cycle pulse: results valid this cycle.
- `div_hi_data`  out  DIV_WIDTH  remainder.
- `div_lo_data`  out  DIV_WIDTH  quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `div_start`=0, `div_end`=0. When `start`=1 and `annul`=0, the block:
  - latches |dividend| and |divisor| (absolute values only when `signed_div`=1);
  - latches the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign);
  - clears the 33-bit partial remainder and the 5-bit iteration counter;
  - moves to CALC.
- CALC, one restoring step per cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor_abs (33-bit);
  - if trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - After 32 steps (counter == 31), move to FIX.
- FIX: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (signed only). Load the output registers. Move to DONE.
- DONE: `div_end`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE. A back-to-back DIV is accepted in the following IDLE cycle.
- `div_start`=1 in CALC and FIX. `div_end`=1 only in DONE. They are never both 1.
- Handshake encoding seen downstream: (0,0) = needs start, (1,0) = busy, (0,1) = done.
- Output registers hold their last result until the next FIX. They are not cleared on return to IDLE.
- Divide by zero, detected at acceptance: skip CALC, go directly to FIX.
  - lo = 0xFFFF_FFFF, hi = raw dividend.
  - No sign correction is applied.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): the result is lo = 0x8000_0000, hi = 0. This falls out of the datapath and needs no special case.
- `annul`=1 in any state: next state IDLE, no `div_end`, output registers unchanged. `annul` has priority over `start`.

## Timing
- Reset (async, `reset`=0): state IDLE, `div_start`=0, `div_end`=0, `div_hi_data`=0, `div_lo_data`=0, counter 0.
- `start` sampled at edge T:
  - CALC spans T+1..T+32;
  - FIX occurs at T+33;
  - `div_end`=1 during T+34 (the cycle after edge T+34);
  - IDLE from T+35.
- Fixed latency: 34 cycles from acceptance to `div_end`. This drops to 2 cycles under early-out (see Configuration) or divide by zero.
- `div_start` rises the cycle after acceptance. The downstream stall status therefore reads (0,0) for the acceptance cycle itself, which is still a stall.
- Reset asserted mid-operation: immediate return to IDLE with all outputs zero. The operation is not resumed.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - at acceptance, if |dividend| < |divisor| (unsigned compare of the absolute values), skip CALC and go to FIX with quo = 0, rem = |dividend|;
  - normal sign correction then applies;
  - latency is 2 cycles (`div_end` at T+2).
- Not defined: every non-zero-divisor operation takes the full 34 cycles. Results are identical either way; only latency differs.

## Structure
- `defines.vh` gains:
  - the state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_FIX`, `DIV_DONE`;
  - `DIV_ITER` (32);
  - the existing `DATALENGTH` and `ZEROWORD`.
- One combinational sub-module is natural: `div_step`, which takes {rem, quo, divisor_abs} and produces the next {rem, quo}. It isolates the restoring step for unit testing.

## Test plan
- DIVU 100 / 7 -> after 34 cycles `div_end` pulses for 1 cycle; lo = 14, hi = 2; `div_start` high for cycles 1..33.
- DIV −7 / 2 -> lo = 0xFFFF_FFFD (−3), hi = 0xFFFF_FFFF (−1). DIV 7 / −2 -> lo = −3, hi = 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0. DIVU 5 / 0 -> lo = 0xFFFF_FFFF, hi = 5, `div_end` at T+2.
- Start DIVU 1000 / 3, assert `annul` at cycle 10 -> IDLE next cycle, no `div_end`, outputs keep the previous result. Assert `reset` low at cycle 20 of a new operation -> all outputs 0 immediately.
- Back-to-back: DIVU 9 / 3, then `start` held for 20 / 6 -> second acceptance in the IDLE cycle after DONE; results 3/0 then 3/2.
- With `DIV_EARLY_OUT_EN`: DIVU 3 / 10 -> lo = 0, hi = 3, `div_end` at T+2. Without it -> same result at T+34.
